step_dir_motion_ctrl: RTL and testbench
=======================================

Name: step_dir_motion_ctrl

Overview:
Parametrised step/dir motor channel. Accepts move commands over a valid/ready handshake and generates exactly N step pulses with a programmable direction-setup delay. A symmetric linear-ramp speed profile accelerates from a start period to a minimum period, then decelerates. Tracks a signed absolute position and sits between the command/host interface and the external stepper driver pins.

Parameters:
POS_W, 20, width of signed position counter
DIV_W, 13, width of period/divider fields (clocks per step period)
CNT_W, 16, width of step-count field
PULSE_W, 2, step high time in clocks (>=1)
DIR_SETUP, 4, clocks from dir update to first step rising edge (>=1)

Ports:
CLK  input  1  clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  move command valid
cmd_ready  output  1  high in IDLE only
cmd_dir  input  1  1 = positive direction
cmd_steps  input  CNT_W  number of steps to issue
cmd_div_start  input  DIV_W  start/end period, clocks
cmd_div_min  input  DIV_W  cruise (minimum) period, clocks
cmd_div_step  input  DIV_W  period change per step during ramp
abort  input  1  request stop after current period
dir  output  1  driver direction pin
step  output  1  driver step pin
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse on move completion or abort
steps_left  output  CNT_W  remaining steps, including the current one
cur_position  output  POS_W  signed absolute position

Behaviour:
- Reset, synchronous, overrides all: state=IDLE; dir=0, step=0, busy=0, done=0, cmd_ready=1, steps_left=0, cur_position=0, internal counters=0.
- Effective period p = max(cur_div, PULSE_W+1). step is high for the first PULSE_W clocks of each period and low for the rest.
- FSM: IDLE -> SETUP -> RUN -> IDLE.
- IDLE:
  - Accept when cmd_valid & cmd_ready in cycle T.
  - Latch all fields. dir<=cmd_dir at T+1. cur_div<=cmd_div_start, acc_cnt<=0, steps_left<=cmd_steps.
  - cmd_steps=0: no step, dir still updated, done=1 at T+1, stay IDLE.
- SETUP: hold for DIR_SETUP clocks. First step rising edge occurs at T+1+DIR_SETUP.
- RUN, at end of each period:
  - steps_left decrements.
  - If steps_left reaches 0: go to IDLE; done=1 and cmd_ready=1 in the cycle after the last period ends.
  - Otherwise the next period starts with no gap.
- Next-period rule, evaluated on the remaining count rem after the decrement:
  - If rem <= acc_cnt: decelerate. cur_div = min(cur_div + div_step, div_start); acc_cnt decrements.
  - Else if cur_div > div_min: accelerate. cur_div = max(cur_div - div_step, div_min); acc_cnt increments.
  - Else hold.
  - Arithmetic is DIV_W+1 bits internally, saturating with no wrap.
  - div_step=0 or div_min>=div_start gives constant period div_start.
- Position updates in the cycle step rises (registered 0->1): +1 if dir=1, else -1. Two's complement wrap at POS_W (max positive +1 -> min negative).
- Abort:
  - In RUN: the current period completes, then IDLE with done pulse. steps_left holds the untaken count (including 0 if it was the last step).
  - In SETUP: immediate IDLE, done=1 next cycle, no step issued.
  - In IDLE: ignored.
- cmd_valid while busy: ignored, not queued.
- Reset mid-move: step drops to 0 in the next cycle; position clears.

Optional Feature:
POS_LOAD_EN
- Defined: adds inputs pos_load (1) and pos_load_val (POS_W).
  - pos_load=1 sets cur_position<=pos_load_val next cycle.
  - It takes priority over a simultaneous step increment; that step is not counted.
  - It is legal in any state.
  - Reset still wins over load.
- Undefined: ports are absent; position changes only by stepping and reset.

Test Plan:
1. Constant speed, PULSE_W=2, DIR_SETUP=4. Accept at T with steps=3, start=10, min=10, div_step=0, dir=1 -> step rises at T+5, T+15, T+25, each high 2 clocks; cur_position=3; done pulse at T+35.
2. Ramp with steps=6, start=20, min=10, div_step=5 -> step-rise intervals 20,15,10,10,15,20; acc_cnt returns to 0; done one cycle after the final 20-clock period.
3. Abort during the 2nd period of a 100-step move -> exactly 2 steps issued; done pulse; steps_left=98; cmd_ready=1.
4. Position wrap: load position to 524287 (POS_LOAD_EN), issue 1 step with dir=1 -> cur_position=-524288. Then issue 1 step with dir=0 -> cur_position=524287.
5. Edge cases:
   - cmd_steps=0 -> no step, done at T+1.
   - start=1 -> period clamps to 3.
   - cmd_valid while busy -> ignored.
6. Reset asserted while step is high mid-move -> next cycle step=0, busy=0, cur_position=0, cmd_ready=1.

Source files
------------

// File: rtl/step_dir_motion_ctrl.sv
// Step/dir motor channel: move command -> N step pulses with dir setup and symmetric linear speed ramp.
// Optional POS_LOAD_EN adds a position load port; cmd_ready only in IDLE, busy commands are dropped.
module step_dir_motion_ctrl #(
    parameter int POS_W     = 20,
    parameter int DIV_W     = 13,
    parameter int CNT_W     = 16,
    parameter int PULSE_W   = 2,
    parameter int DIR_SETUP = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [CNT_W-1:0]  cmd_steps,
    input  logic [DIV_W-1:0]  cmd_div_start,
    input  logic [DIV_W-1:0]  cmd_div_min,
    input  logic [DIV_W-1:0]  cmd_div_step,
    input  logic              abort,
`ifdef POS_LOAD_EN
    input  logic              pos_load,
    input  logic [POS_W-1:0]  pos_load_val,
`endif
    output logic              dir,
    output logic              step,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  steps_left,
    output logic [POS_W-1:0]  cur_position
);

    typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;

    localparam int SET_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(DIR_SETUP - 1);
    localparam logic [DIV_W:0]   P_MIN    = (DIV_W+1)'(PULSE_W + 1);
    localparam logic [DIV_W:0]   P_HIGH   = (DIV_W+1)'(PULSE_W);

    state_t             state_q, state_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic [DIV_W-1:0]   per_cnt_q, per_cnt_d;
    logic [DIV_W-1:0]   cur_div_q, cur_div_d;
    logic [DIV_W-1:0]   div_start_q, div_start_d;
    logic [DIV_W-1:0]   div_min_q, div_min_d;
    logic [DIV_W-1:0]   div_step_q, div_step_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   steps_left_q, steps_left_d;
    logic               abort_pend_q, abort_pend_d;
    logic               dir_q, dir_d;
    logic               step_q, step_d;
    logic               done_q, done_d;
    logic [POS_W-1:0]   pos_q, pos_d;

    logic [DIV_W:0]     eff_p, sum, diff;
    logic [CNT_W-1:0]   rem;
    logic               period_end;

    always_comb begin
        state_d      = state_q;
        set_cnt_d    = set_cnt_q;
        per_cnt_d    = per_cnt_q;
        cur_div_d    = cur_div_q;
        div_start_d  = div_start_q;
        div_min_d    = div_min_q;
        div_step_d   = div_step_q;
        acc_d        = acc_q;
        steps_left_d = steps_left_q;
        abort_pend_d = abort_pend_q;
        dir_d        = dir_q;
        done_d       = 1'b0;

        eff_p      = ({1'b0, cur_div_q} > P_MIN) ? {1'b0, cur_div_q} : P_MIN;
        period_end = ({1'b0, per_cnt_q} == (eff_p - (DIV_W+1)'(1)));
        rem        = steps_left_q - CNT_W'(1);
        sum        = {1'b0, cur_div_q} + {1'b0, div_step_q};
        diff       = {1'b0, cur_div_q} - {1'b0, div_step_q};

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dir_d        = cmd_dir;
                    cur_div_d    = cmd_div_start;
                    div_start_d  = cmd_div_start;
                    div_min_d    = cmd_div_min;
                    div_step_d   = cmd_div_step;
                    acc_d        = '0;
                    steps_left_d = cmd_steps;
                    abort_pend_d = 1'b0;
                    set_cnt_d    = '0;
                    per_cnt_d    = '0;
                    if (cmd_steps == '0) done_d  = 1'b1;
                    else                 state_d = SETUP;
                end
            end
            SETUP: begin
                if (abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (set_cnt_q == SET_LAST) begin
                    state_d   = RUN;
                    per_cnt_d = '0;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            RUN: begin
                if (abort) abort_pend_d = 1'b1;
                if (period_end) begin
                    steps_left_d = rem;
                    per_cnt_d    = '0;
                    if (rem == '0 || abort || abort_pend_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (rem <= acc_q) begin
                        // Decelerate, saturating back at the start period.
                        cur_div_d = (sum > {1'b0, div_start_q}) ? div_start_q : sum[DIV_W-1:0];
                        acc_d     = acc_q - CNT_W'(1);
                    end else if (cur_div_q > div_min_q) begin
                        cur_div_d = (diff[DIV_W] || diff < {1'b0, div_min_q}) ? div_min_q : diff[DIV_W-1:0];
                        acc_d     = acc_q + CNT_W'(1);
                    end
                end else begin
                    per_cnt_d = per_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        step_d = (state_d == RUN) && ({1'b0, per_cnt_d} < P_HIGH);

        pos_d = pos_q;
        if (step_d && !step_q) pos_d = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
`ifdef POS_LOAD_EN
        if (pos_load) pos_d = pos_load_val;
`endif
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= IDLE;
            set_cnt_q    <= '0;
            per_cnt_q    <= '0;
            cur_div_q    <= '0;
            div_start_q  <= '0;
            div_min_q    <= '0;
            div_step_q   <= '0;
            acc_q        <= '0;
            steps_left_q <= '0;
            abort_pend_q <= 1'b0;
            dir_q        <= 1'b0;
            step_q       <= 1'b0;
            done_q       <= 1'b0;
            pos_q        <= '0;
        end else begin
            state_q      <= state_d;
            set_cnt_q    <= set_cnt_d;
            per_cnt_q    <= per_cnt_d;
            cur_div_q    <= cur_div_d;
            div_start_q  <= div_start_d;
            div_min_q    <= div_min_d;
            div_step_q   <= div_step_d;
            acc_q        <= acc_d;
            steps_left_q <= steps_left_d;
            abort_pend_q <= abort_pend_d;
            dir_q        <= dir_d;
            step_q       <= step_d;
            done_q       <= done_d;
            pos_q        <= pos_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign dir          = dir_q;
    assign step         = step_q;
    assign done         = done_q;
    assign steps_left   = steps_left_q;
    assign cur_position = pos_q;

endmodule

// File: tb/tb_step_dir_motion_ctrl.sv
// Bench for step_dir_motion_ctrl: directed and random moves checked against a timeline model.
module tb_step_dir_motion_ctrl;
    localparam int POS_W = 20, DIV_W = 13, CNT_W = 16, PULSE_W = 2, DIR_SETUP = 4;

    logic CLK = 1'b0;
    logic reset, cmd_valid, cmd_dir, abort;
    logic [CNT_W-1:0] cmd_steps;
    logic [DIV_W-1:0] cmd_div_start, cmd_div_min, cmd_div_step;
    logic cmd_ready, dir, step, busy, done;
    logic [CNT_W-1:0] steps_left;
    logic [POS_W-1:0] cur_position;
`ifdef POS_LOAD_EN
    logic pos_load;
    logic [POS_W-1:0] pos_load_val;
`endif

    step_dir_motion_ctrl #(.POS_W(POS_W), .DIV_W(DIV_W), .CNT_W(CNT_W),
                           .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP)) dut (
        .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_div_start(cmd_div_start),
        .cmd_div_min(cmd_div_min), .cmd_div_step(cmd_div_step), .abort(abort),
`ifdef POS_LOAD_EN
        .pos_load(pos_load), .pos_load_val(pos_load_val),
`endif
        .dir(dir), .step(step), .busy(busy), .done(done),
        .steps_left(steps_left), .cur_position(cur_position));

    always #5 CLK = ~CLK;

    int total = 0, bad = 0;
    int cyc = 0;
    int rise_q[$], width_q[$], done_q[$], exp_q[$];
    int exp_done;
    logic [POS_W-1:0] exp_pos = '0;
    logic step_prev = 1'b0;
    int hi_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Observe pin activity just after each edge; cyc then names the current cycle.
    always @(posedge CLK) begin
        #1;
        if (step && !step_prev) rise_q.push_back(cyc);
        if (step) hi_cnt++;
        else if (step_prev) begin
            width_q.push_back(hi_cnt);
            hi_cnt = 0;
        end
        step_prev = step;
        if (done) done_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        rise_q.delete(); width_q.delete(); done_q.delete();
    endtask

    // Expected step-rise cycles and done cycle from the ramp rules, plain integer arithmetic.
    task automatic model(input int t0, input bit d, input int n, input int st, input int mn, input int ds);
        int t, cur, acc, rem, p;
        exp_q.delete();
        t = t0 + 1 + DIR_SETUP;
        cur = st; acc = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(t);
            p = (cur > PULSE_W + 1) ? cur : PULSE_W + 1;
            t += p;
            rem = n - 1 - i;
            if (rem == 0) break;
            if (rem <= acc) begin
                cur = (cur + ds > st) ? st : cur + ds;
                acc--;
            end else if (cur > mn) begin
                cur = (cur - ds < mn) ? mn : cur - ds;
                acc++;
            end
        end
        exp_done = (n == 0) ? t0 + 1 : t;
        if (d) exp_pos = exp_pos + POS_W'(n);
        else   exp_pos = exp_pos - POS_W'(n);
    endtask

    task automatic send(input bit d, input int n, input int st, input int mn, input int ds, output int t0);
        @(negedge CLK);
        chk("cmd_ready_idle", cmd_ready, 1);
        clear_obs();
        cmd_valid = 1'b1; cmd_dir = d; cmd_steps = CNT_W'(n);
        cmd_div_start = DIV_W'(st); cmd_div_min = DIV_W'(mn); cmd_div_step = DIV_W'(ds);
        t0 = cyc;
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge CLK);
        end
        chk({tag, "_done_seen"}, ok, 1);
    endtask

    task automatic finish_move(input string tag, input bit d);
        wait_done(tag, 5000);
        chk({tag, "_rise_cnt"}, rise_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk({tag, "_rise_t"}, (i < rise_q.size()) ? rise_q[i] : -1, exp_q[i]);
        for (int i = 0; i < width_q.size(); i++)
            chk({tag, "_width"}, width_q[i], PULSE_W);
        chk({tag, "_done_cnt"}, done_q.size(), 1);
        chk({tag, "_done_t"}, (done_q.size() > 0) ? done_q[0] : -1, exp_done);
        chk({tag, "_pos"}, cur_position, exp_pos);
        chk({tag, "_left"}, steps_left, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_dir"}, dir, d);
    endtask

    task automatic run_move(input string tag, input bit d, input int n, input int st, input int mn, input int ds);
        int t0;
        send(d, n, st, mn, ds, t0);
        model(t0, d, n, st, mn, ds);
        finish_move(tag, d);
    endtask

    initial begin
        int t0;
        bit got;
        reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; abort = 1'b0;
        cmd_steps = '0; cmd_div_start = '0; cmd_div_min = '0; cmd_div_step = '0;
`ifdef POS_LOAD_EN
        pos_load = 1'b0; pos_load_val = '0;
`endif
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        chk("rst_dir", dir, 0);
        chk("rst_step", step, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_left", steps_left, 0);
        chk("rst_pos", cur_position, 0);

        run_move("const", 1'b1, 3, 10, 10, 0);
        run_move("ramp", 1'b1, 6, 20, 10, 5);
        run_move("ramp_short", 1'b0, 4, 20, 10, 5);
        run_move("ramp_clip", 1'b1, 7, 20, 12, 5);
        run_move("zero", 1'b0, 0, 10, 10, 0);
        run_move("clamp", 1'b1, 3, 1, 1, 0);
        run_move("min_ge_start", 1'b0, 3, 8, 15, 4);

        // Abort in the second period of a long move.
        send(1'b1, 100, 10, 10, 0, t0);
        while (cyc < t0 + 1 + DIR_SETUP + 13) @(negedge CLK);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        wait_done("abort_run", 500);
        exp_pos = exp_pos + POS_W'(2);
        chk("abort_run_rises", rise_q.size(), 2);
        chk("abort_run_done_t", (done_q.size() > 0) ? done_q[0] : -1, t0 + 25);
        chk("abort_run_left", steps_left, 98);
        chk("abort_run_ready", cmd_ready, 1);
        chk("abort_run_pos", cur_position, exp_pos);

        // Abort during direction setup.
        send(1'b0, 5, 10, 10, 0, t0);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        wait_done("abort_setup", 50);
        chk("abort_setup_done_t", (done_q.size() > 0) ? done_q[0] : -1, t0 + 2);
        repeat (10) @(negedge CLK);
        chk("abort_setup_rises", rise_q.size(), 0);
        chk("abort_setup_left", steps_left, 5);
        chk("abort_setup_pos", cur_position, exp_pos);

        // Abort while idle has no effect.
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        @(negedge CLK);
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_done", done, 0);

        // Command offered while busy must be dropped.
        send(1'b1, 4, 12, 6, 3, t0);
        model(t0, 1'b1, 4, 12, 6, 3);
        @(negedge CLK);
        chk("busy_ready_low", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd7;
        repeat (3) @(negedge CLK);
        cmd_valid = 1'b0;
        finish_move("busy_ign", 1'b1);
        repeat (5) @(negedge CLK);
        chk("busy_ign_idle", busy, 0);
        chk("busy_ign_no_extra", rise_q.size(), 4);

        // Random moves against the model.
        for (int k = 0; k < 8; k++) begin
            run_move("rand", 1'($urandom_range(0, 1)), int'($urandom_range(1, 10)),
                     int'($urandom_range(1, 40)), int'($urandom_range(1, 40)),
                     int'($urandom_range(0, 8)));
        end

`ifdef POS_LOAD_EN
        @(negedge CLK);
        pos_load = 1'b1; pos_load_val = 20'd524287;
        @(negedge CLK);
        pos_load = 1'b0;
        exp_pos = 20'd524287;
        chk("load_pos", cur_position, exp_pos);
        run_move("wrap_up", 1'b1, 1, 5, 5, 0);
        chk("wrap_up_min", cur_position, 20'h80000);
        run_move("wrap_dn", 1'b0, 1, 5, 5, 0);
        chk("wrap_dn_max", cur_position, 20'h7FFFF);
`endif

        // Reset while step is high mid-move.
        send(1'b1, 5, 10, 10, 0, t0);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (step) begin got = 1'b1; break; end
            @(negedge CLK);
        end
        chk("mid_rst_step_seen", got, 1);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        exp_pos = '0;
        chk("mid_rst_step", step, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pos", cur_position, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        clear_obs();
        run_move("after_rst", 1'b0, 2, 6, 4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
